mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of exec: takes one resolved op per handshake (ALU result or load/store
//  address + store data), performs the data-memory transaction over a req/ack bus, aligns/extends load data, and
//  presents a single writeback record (rd, data, we, fault flags) to the register-file writeback path.
// PARAMETERS
//  TIMEOUT   16   cycles dmem_req may stay unacknowledged before the op completes with bus_err (>=2)
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst           in   1   asynchronous, active-high reset
//  in_valid      in   1   exec presents an op
//  in_ready      out  1   stage can accept (high only in IDLE)
//  in_is_load    in   1   op is a load (LB/LH/LW/LBU/LHU)
//  in_is_store   in   1   op is a store (SB/SH/SW); both low = ALU pass-through
//  in_funct3     in   3   RV32I width/sign code
//  in_rd         in   5   destination register
//  in_addr       in   32  effective address (loads/stores) or ALU result (pass-through)
//  in_wdata      in   32  rs2 value for stores
//  dmem_req      out  1   bus request, held until ack or timeout
//  dmem_we       out  1   1 = write
//  dmem_addr     out  32  word address, {addr[31:2],2'b00}
//  dmem_wstrb    out  4   byte enables
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_rdata    in   32  read data, valid with dmem_ack
//  dmem_ack      in   1   one-cycle completion strobe
//  wb_valid      out  1   writeback record valid, held until wb_ready
//  wb_ready      in   1   writeback consumer accepts
//  wb_rd         out  5   destination register
//  wb_data       out  32  value to write
//  wb_we         out  1   register write enable
//  wb_misalign   out  1   address misaligned for access width
//  wb_illegal    out  1   memory op with funct3 in {011,110,111}
//  wb_bus_err    out  1   bus timeout
// BEHAVIOUR
//  Reset (async): state IDLE; dmem_req/dmem_we/wb_valid/wb_we/flags=0; dmem_addr/wstrb/wdata/wb_rd/wb_data=0;
//   timeout counter=0. Reset mid-transaction drops dmem_req immediately; late ack after reset is ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE; accept = in_valid & in_ready (IDLE only).
//   IDLE, accept pass-through: -> DONE next cycle, wb_data=in_addr, wb_we=(rd!=0). Latency 1.
//   IDLE, accept mem op with misalign (H: addr[0]!=0; W: addr[1:0]!=0) or illegal funct3: no bus access,
//    -> DONE with wb_we=0 and matching flag set; illegal takes precedence over misalign.
//   IDLE, accept legal mem op: -> BUSY, dmem_req=1 from next cycle; addr/we/wstrb/wdata registered, stable until exit.
//   BUSY: counter increments each cycle; dmem_ack sampled high -> dmem_req=0, -> DONE. Load: wb_data=extracted
//    lane, wb_we=(rd!=0). Store: wb_we=0. Min load/store latency 2 cycles (ack in first BUSY cycle).
//   BUSY, counter reaches TIMEOUT-1 without ack: dmem_req=0, -> DONE, wb_bus_err=1, wb_we=0; ack same cycle wins.
//   DONE: wb_valid=1, record stable; wb_ready -> IDLE, wb_valid=0 next cycle. No new op accepted in DONE.
//  dmem_ack outside BUSY ignored. Store strobes: SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111;
//   wdata SB {4{b}}, SH {2{h}}, SW word. Load lane = rdata >> (8*a[1:0]);
//   LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW unchanged.
//  wb_we never asserted when rd==0 or any flag set; flags only meaningful while wb_valid.
// STRUCTURE
//  Shared package riscv_pkg: opcode/funct3 localparams (F3_B/H/W/BU/HU), typedef enum {IDLE,BUSY,DONE} mem_state_t,
//   typedef struct wb_rec_t {rd,data,we,misalign,illegal,bus_err}.
//  One sub-module: load_align (combinational: rdata, a[1:0], funct3 -> 32b extended value). FSM, counter,
//   store-lane formatting stay in mem_stage.
// TESTING
//  LW addr 0x100, rdata 0xDEADBEEF, ack 1st BUSY cycle -> wb_data 0xDEADBEEF, wb_rd kept, wb_we=1, 2-cycle latency.
//  LB addr 0x103 rdata 0x80FF_0000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
//  SB addr 0x201 wdata 0x000000AB -> dmem_wstrb 4'b0010, dmem_wdata 0xABABABAB, dmem_addr 0x200, wb_we=0.
//  SW addr 0x302 -> no dmem_req, wb_misalign=1, wb_we=0; funct3 3'b011 load -> wb_illegal=1, no access.
//  Load with no ack, TIMEOUT=16 -> dmem_req drops after 16 BUSY cycles, wb_bus_err=1; ack later ignored.
//  rst pulsed mid-BUSY -> dmem_req low same cycle, in_ready=1 after release; wb_ready low 5 cycles -> record held.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, FSM states and the
// writeback record handed to the register-file path.
package riscv_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic             we;
    logic             misalign;
    logic             illegal;
    logic             bus_err;
  } wb_rec_t;

  // funct3 codes that no RV32I load/store encodes
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed lane of a bus word and sign/zero-extends
// it according to the load's funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_lane,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;

  assign w_shift = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_data = {24'h000000, w_shift[7:0]};
      F3_HU:   o_data = {16'h0000, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one resolved op, runs the data-memory req/ack transaction,
// aligns load data and holds a single writeback record until the consumer takes it.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [STRB_W-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_we,
  output logic              wb_misalign,
  output logic              wb_illegal,
  output logic              wb_bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  mem_state_t        r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic              r_in_ready, w_in_ready_n;
  logic              r_req, w_req_n;
  logic              r_we, w_we_n;
  logic [XLEN-1:0]   r_addr, w_addr_n;
  logic [STRB_W-1:0] r_wstrb, w_wstrb_n;
  logic [XLEN-1:0]   r_wdata, w_wdata_n;
  logic              r_is_load, w_is_load_n;
  logic [2:0]        r_f3, w_f3_n;
  logic [1:0]        r_lane, w_lane_n;
  wb_rec_t           r_wb, w_wb_n;
  logic              r_wb_valid, w_wb_valid_n;

  logic [STRB_W-1:0] w_st_wstrb;
  logic [XLEN-1:0]   w_st_wdata;
  logic [XLEN-1:0]   w_load_val;

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_f3),
    .o_data   (w_load_val)
  );

  // Store lane formatting: data replicated across lanes, strobes pick the target bytes
  always_comb begin
    w_st_wstrb = 4'b1111;
    w_st_wdata = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        w_st_wstrb = 4'b0001 << in_addr[1:0];
        w_st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_st_wstrb = 4'b0011 << in_addr[1:0];
        w_st_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_req_n      = r_req;
    w_we_n       = r_we;
    w_addr_n     = r_addr;
    w_wstrb_n    = r_wstrb;
    w_wdata_n    = r_wdata;
    w_is_load_n  = r_is_load;
    w_f3_n       = r_f3;
    w_lane_n     = r_lane;
    w_wb_n       = r_wb;
    w_wb_valid_n = r_wb_valid;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_wb_n    = '0;
          w_wb_n.rd = in_rd;
          if (!in_is_load && !in_is_store) begin
            w_wb_n.data  = in_addr;
            w_wb_n.we    = (in_rd != '0);
            w_state_n    = DONE;
            w_wb_valid_n = 1'b1;
          end else if (f3_illegal(in_funct3)) begin
            w_wb_n.illegal = 1'b1;
            w_state_n      = DONE;
            w_wb_valid_n   = 1'b1;
          end else if (f3_misalign(in_funct3, in_addr[1:0])) begin
            w_wb_n.misalign = 1'b1;
            w_state_n       = DONE;
            w_wb_valid_n    = 1'b1;
          end else begin
            w_state_n   = BUSY;
            w_cnt_n     = '0;
            w_req_n     = 1'b1;
            w_we_n      = !in_is_load;
            w_addr_n    = {in_addr[XLEN-1:2], 2'b00};
            w_wstrb_n   = in_is_load ? 4'b0000 : w_st_wstrb;
            w_wdata_n   = w_st_wdata;
            w_is_load_n = in_is_load;
            w_f3_n      = in_funct3;
            w_lane_n    = in_addr[1:0];
          end
        end
      end
      BUSY: begin
        w_cnt_n = r_cnt + CNT_W'(1);
        // An ack in the final allowed cycle still completes the access normally
        if (dmem_ack) begin
          w_req_n      = 1'b0;
          w_state_n    = DONE;
          w_wb_valid_n = 1'b1;
          if (r_is_load) begin
            w_wb_n.data = w_load_val;
            w_wb_n.we   = (r_wb.rd != '0);
          end else begin
            w_wb_n.we = 1'b0;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_req_n        = 1'b0;
          w_state_n      = DONE;
          w_wb_valid_n   = 1'b1;
          w_wb_n.bus_err = 1'b1;
          w_wb_n.we      = 1'b0;
        end
      end
      DONE: begin
        if (wb_ready) begin
          w_state_n    = IDLE;
          w_wb_valid_n = 1'b0;
        end
      end
      default: w_state_n = IDLE;
    endcase

    w_in_ready_n = (w_state_n == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_is_load  <= 1'b0;
      r_f3       <= '0;
      r_lane     <= '0;
      r_wb       <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_in_ready <= w_in_ready_n;
      r_req      <= w_req_n;
      r_we       <= w_we_n;
      r_addr     <= w_addr_n;
      r_wstrb    <= w_wstrb_n;
      r_wdata    <= w_wdata_n;
      r_is_load  <= w_is_load_n;
      r_f3       <= w_f3_n;
      r_lane     <= w_lane_n;
      r_wb       <= w_wb_n;
      r_wb_valid <= w_wb_valid_n;
    end
  end

  assign in_ready    = r_in_ready;
  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wstrb  = r_wstrb;
  assign dmem_wdata  = r_wdata;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb.rd;
  assign wb_data     = r_wb.data;
  assign wb_we       = r_wb.we;
  assign wb_misalign = r_wb.misalign;
  assign wb_illegal  = r_wb.illegal;
  assign wb_bus_err  = r_wb.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-mid-transaction sequence and
// randomized ops checked against a behavioural model of the stage.
module tb_mem_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_addr, in_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_ready, wb_we, wb_misalign, wb_illegal, wb_bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_addr(in_addr), .in_wdata(in_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .wb_misalign(wb_misalign), .wb_illegal(wb_illegal), .wb_bus_err(wb_bus_err)
  );

  typedef struct packed {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned dly;   // BUSY cycle (0-based) in which the bus acks
    int unsigned hold;  // cycles wb_ready stays low once wb_valid is seen
  } op_t;

  typedef struct packed {
    logic [31:0] data;
    bit          we, mis, ill, berr;
    int unsigned lat, reqc;
    logic [31:0] daddr;
    logic [3:0]  wstrb;
    logic [31:0] dwdata;
  } exp_t;

  typedef struct packed {
    op_t  op;
    exp_t e;
  } vec_t;

  typedef struct packed {
    bit          done, ready_busy, req_after, held, valid_after, ready_after;
    int unsigned lat, reqc;
    logic [31:0] daddr, dwdata, data;
    logic        dwe;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic        we, mis, ill, berr;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input int unsigned dly, input int unsigned hold,
                              input logic [31:0] data, input bit we, input bit mis, input bit ill,
                              input bit berr, input int unsigned lat, input int unsigned reqc,
                              input logic [31:0] daddr, input logic [3:0] wstrb, input logic [31:0] dwdata);
    vec_t v;
    v.op = '{ld: ld, st: st, f3: f3, rd: rd, addr: addr, wdata: wdata, rdata: rdata, dly: dly, hold: hold};
    v.e  = '{data: data, we: we, mis: mis, ill: ill, berr: berr, lat: lat, reqc: reqc,
             daddr: daddr, wstrb: wstrb, dwdata: dwdata};
    return v;
  endfunction

  // Behavioural reference: outcome of one op from the architectural rules
  function automatic exp_t model(input op_t op);
    exp_t e;
    longint unsigned size, a, raw, v, m;
    e = '0;
    if (!op.ld && !op.st) begin
      e.data = op.addr;
      e.we   = (op.rd != 5'd0);
      e.lat  = 1;
      return e;
    end
    e.ill = (op.f3 == 3'd3) || (op.f3 == 3'd6) || (op.f3 == 3'd7);
    size  = 64'd1 << (op.f3 % 3'd4);
    a     = 64'(op.addr % 32'd4);
    e.mis = !e.ill && ((a % size) != 64'd0);
    if (e.ill || e.mis) begin
      e.lat = 1;
      return e;
    end
    e.daddr = op.addr - 32'(a);
    if (op.dly < TO) begin
      e.lat  = op.dly + 2;
      e.reqc = op.dly + 1;
    end else begin
      e.lat  = TO + 1;
      e.reqc = TO;
      e.berr = 1'b1;
    end
    if (op.st) begin
      e.wstrb = 4'(((64'd1 << size) - 64'd1) << a);
      for (int i = 0; i < 4; i++)
        e.dwdata[8*i +: 8] = 8'(64'(op.wdata) >> (64'd8 * (64'(i) % size)));
    end else if (!e.berr) begin
      raw = 64'(op.rdata) >> (64'd8 * a);
      m   = (64'd1 << (64'd8 * size)) - 64'd1;
      v   = raw & m;
      if (op.f3 < 3'd4 && size < 64'd4 && v >= (64'd1 << (64'd8 * size - 64'd1)))
        v = v + (64'hFFFF_FFFF - m);
      e.data = 32'(v);
      e.we   = (op.rd != 5'd0);
    end
    return e;
  endfunction

  task automatic do_op(input op_t op, output obs_t ob);
    int unsigned seen;
    ob = '0;
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1; in_is_load = op.ld; in_is_store = op.st; in_funct3 = op.f3;
    in_rd = op.rd; in_addr = op.addr; in_wdata = op.wdata;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    seen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (c == 1) ob.ready_busy = in_ready;
      if (wb_valid === 1'b1) begin
        ob.done = 1'b1;
        ob.lat  = c;
        break;
      end
      if (dmem_req === 1'b1) begin
        if (seen == 0) begin
          ob.daddr = dmem_addr; ob.dwe = dmem_we; ob.wstrb = dmem_wstrb; ob.dwdata = dmem_wdata;
        end
        dmem_ack   = (seen == op.dly);
        dmem_rdata = op.rdata;
        seen++;
      end
    end
    ob.reqc = seen;
    if (!ob.done) return;
    ob.rd = wb_rd; ob.data = wb_data; ob.we = wb_we;
    ob.mis = wb_misalign; ob.ill = wb_illegal; ob.berr = wb_bus_err;
    ob.req_after = dmem_req;
    ob.held = 1'b1;
    // stray acks while the record is parked must not disturb it
    for (int h = 0; h < int'(op.hold); h++) begin
      dmem_ack = 1'b1; dmem_rdata = ~op.rdata;
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_rd !== ob.rd || wb_data !== ob.data || wb_we !== ob.we ||
          wb_misalign !== ob.mis || wb_illegal !== ob.ill || wb_bus_err !== ob.berr)
        ob.held = 1'b0;
    end
    dmem_ack = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk);
    #1 wb_ready = 1'b0;
    @(negedge clk);
    ob.valid_after = wb_valid;
    ob.ready_after = in_ready;
  endtask

  task automatic check_op(input string tag, input op_t op, input exp_t e, input obs_t ob);
    chk({tag, ".done"}, 32'(ob.done), 32'd1);
    if (!ob.done) return;
    chk({tag, ".rd"}, 32'(ob.rd), 32'(op.rd));
    chk({tag, ".we"}, 32'(ob.we), 32'(e.we));
    chk({tag, ".misalign"}, 32'(ob.mis), 32'(e.mis));
    chk({tag, ".illegal"}, 32'(ob.ill), 32'(e.ill));
    chk({tag, ".bus_err"}, 32'(ob.berr), 32'(e.berr));
    chk({tag, ".latency"}, ob.lat, e.lat);
    chk({tag, ".req_cycles"}, ob.reqc, e.reqc);
    chk({tag, ".ready_busy"}, 32'(ob.ready_busy), 32'd0);
    chk({tag, ".req_after"}, 32'(ob.req_after), 32'd0);
    chk({tag, ".held"}, 32'(ob.held), 32'd1);
    chk({tag, ".valid_after"}, 32'(ob.valid_after), 32'd0);
    chk({tag, ".ready_after"}, 32'(ob.ready_after), 32'd1);
    if (!op.st && !e.mis && !e.ill && !e.berr) chk({tag, ".data"}, ob.data, e.data);
    if ((op.ld || op.st) && !e.mis && !e.ill) begin
      chk({tag, ".dmem_addr"}, ob.daddr, e.daddr);
      chk({tag, ".dmem_we"}, 32'(ob.dwe), 32'(op.st));
    end
    if (op.st && !e.mis && !e.ill) begin
      chk({tag, ".dmem_wstrb"}, 32'(ob.wstrb), 32'(e.wstrb));
      chk({tag, ".dmem_wdata"}, ob.dwdata, e.dwdata);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    obs_t ob;
    op_t  op;
    logic [2:0] st_f3 [6];
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    // ld st f3 rd addr wdata rdata dly hold | data we mis ill berr lat reqc daddr wstrb dwdata
    vecs.push_back(mk(1,0,3'd2,5'd5,32'h100,0,32'hDEADBEEF,0,5, 32'hDEADBEEF,1,0,0,0,2,1,32'h100,0,0));
    vecs.push_back(mk(1,0,3'd0,5'd6,32'h103,0,32'h80FF0000,0,0, 32'hFFFFFF80,1,0,0,0,2,1,32'h100,0,0));
    vecs.push_back(mk(1,0,3'd4,5'd6,32'h103,0,32'h80FF0000,0,0, 32'h00000080,1,0,0,0,2,1,32'h100,0,0));
    vecs.push_back(mk(1,0,3'd1,5'd6,32'h102,0,32'h80FF0000,0,0, 32'hFFFF80FF,1,0,0,0,2,1,32'h100,0,0));
    vecs.push_back(mk(1,0,3'd5,5'd2,32'h102,0,32'h80FF0000,3,1, 32'h000080FF,1,0,0,0,5,4,32'h100,0,0));
    vecs.push_back(mk(1,0,3'd0,5'd3,32'h101,0,32'h00007F00,0,0, 32'h0000007F,1,0,0,0,2,1,32'h100,0,0));
    vecs.push_back(mk(0,1,3'd0,5'd7,32'h201,32'hAB,0,0,1, 0,0,0,0,0,2,1,32'h200,4'b0010,32'hABABABAB));
    vecs.push_back(mk(0,1,3'd1,5'd7,32'h202,32'h1234BEEF,0,1,0, 0,0,0,0,0,3,2,32'h200,4'b1100,32'hBEEFBEEF));
    vecs.push_back(mk(0,1,3'd2,5'd4,32'h302,32'h11111111,0,0,0, 0,0,1,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'd3,5'd4,32'h100,0,32'h12345678,0,0, 0,0,0,1,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'd6,5'd4,32'h101,0,32'h12345678,0,0, 0,0,0,1,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'd1,5'd4,32'h101,0,32'h12345678,0,0, 0,0,1,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,3'd0,5'd0,32'h12345678,0,0,0,0, 32'h12345678,0,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,3'd2,5'd9,32'hCAFEF00D,0,0,0,2, 32'hCAFEF00D,1,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'd2,5'd0,32'h104,0,32'h11223344,0,0, 32'h11223344,0,0,0,0,2,1,32'h104,0,0));
    vecs.push_back(mk(1,0,3'd2,5'd8,32'h600,0,32'h99999999,99,3, 0,0,0,0,1,17,16,32'h600,0,0));
    vecs.push_back(mk(1,0,3'd2,5'd10,32'h604,0,32'h0BADF00D,15,0, 32'h0BADF00D,1,0,0,0,17,16,32'h604,0,0));
    vecs.push_back(mk(0,1,3'd2,5'd1,32'h400,32'h55AA55AA,0,20,0, 0,0,0,0,1,17,16,32'h400,4'b1111,32'h55AA55AA));

    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
    in_rd = '0; in_addr = '0; in_wdata = '0; dmem_rdata = '0; dmem_ack = 1'b0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.dmem_req", 32'(dmem_req), 32'd0);
    chk("reset.dmem_addr", dmem_addr, 32'd0);
    chk("reset.wb_valid", 32'(wb_valid), 32'd0);
    chk("reset.wb_we", 32'(wb_we), 32'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    chk("reset.wb_bus_err", 32'(wb_bus_err), 32'd0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, ob);
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, ob);
    end

    // Reset asserted while a load waits for its ack
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_rd = 5'd3; in_addr = 32'h500;
    @(posedge clk);
    #1 in_valid = 1'b0; in_is_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid.req_before", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.req_drop", 32'(dmem_req), 32'd0);
    chk("rstmid.wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("rstmid.late_ack_valid", 32'(wb_valid), 32'd0);
    chk("rstmid.late_ack_req", 32'(dmem_req), 32'd0);
    chk("rstmid.late_ack_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 120; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      op = '0;
      op.ld    = (kind == 1) || (kind == 3);
      op.st    = (kind == 2);
      op.f3    = op.st ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      op.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      op.addr  = $urandom;
      op.wdata = $urandom;
      op.rdata = $urandom;
      op.dly   = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      op.hold  = $urandom_range(0, 2);
      do_op(op, ob);
      check_op($sformatf("rnd%0d", i), op, model(op), ob);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
